// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - control and select bundle for the sequenced one-hot decoder
interface decoder_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  logic                  en;
  logic [1:0]            mode;
  logic [SEL_W-1:0]      sel;
  logic                  start;
  logic [DWELL_W-1:0]    dwell;
  logic [SEL_W-1:0]      last;
  logic [2**SEL_W-1:0]   out;
  logic [SEL_W-1:0]      idx;
  logic                  busy;
  logic                  done;

  modport master (
    output en, mode, sel, start, dwell, last,
    input  out, idx, busy, done
  );

  modport slave (
    input  en, mode, sel, start, dwell, last,
    output out, idx, busy, done
  );
endinterface

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with direct, continuous-scan and single-sweep modes
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_scan_if.slave bus
);
  localparam int N = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, SCAN, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               expired;
  logic [SEL_W-1:0]   idx_next;
  logic [SEL_W-1:0]   step_idx;
  logic [DWELL_W-1:0] step_cnt;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Live dwell compare: lowering dwell below the count forces an advance next edge.
  assign expired  = (cnt_q >= bus.dwell);
  assign idx_next = (idx_q >= bus.last) ? '0 : idx_q + 1'b1;
  assign step_idx = expired ? idx_next : idx_q;
  assign step_cnt = expired ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!bus.en) begin
      out_d = '0;
    end else begin
      case (bus.mode)
        2'b00: begin
          state_d = IDLE;
          idx_d   = bus.sel;
          cnt_d   = '0;
          out_d   = onehot(bus.sel);
          busy_d  = 1'b0;
        end
        2'b01: begin
          if (state_q != SCAN) begin
            state_d = SCAN;
            idx_d   = '0;
            cnt_d   = '0;
            out_d   = onehot({SEL_W{1'b0}});
            busy_d  = 1'b0;
          end else begin
            idx_d = step_idx;
            cnt_d = step_cnt;
            out_d = onehot(step_idx);
          end
        end
        2'b10: begin
          if (state_q == SWEEP) begin
            if (expired && idx_q >= bus.last) begin
              state_d = IDLE;
              cnt_d   = '0;
              out_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = step_idx;
              cnt_d = step_cnt;
              out_d = onehot(step_idx);
            end
          end else if (bus.start) begin
            state_d = SWEEP;
            idx_d   = '0;
            cnt_d   = '0;
            out_d   = onehot({SEL_W{1'b0}});
            busy_d  = 1'b1;
          end else begin
            // Idle sweep (or aborted scan): dark output, idx keeps its last value.
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
            busy_d  = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
